// File: rtl/bf16_mul_pipe_if.sv
// Streaming operand/result bundle for bf16_mul_pipe.
// Operand side: in_valid/in_ready handshake carrying in1, in2.
// Result side: out_valid/out_ready handshake carrying out plus overflow/underflow/invalid flags.
interface bf16_mul_pipe_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in1;
  logic [DATA_WIDTH-1:0] in2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  overflow;
  logic                  underflow;
  logic                  invalid;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, out, overflow, underflow, invalid
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, out, overflow, underflow, invalid
  );
endinterface

// File: rtl/bf16_mul_pipe.sv
// Purpose: pipelined floating-point multiplier (bfloat16 by default) with RNE rounding,
//          zero/inf/NaN handling, subnormal flush and overflow/underflow/invalid flags.
// Latency: 3 cycles from accepted operands to out_valid; one result per cycle.
// Backpressure: the whole pipe stalls while a result is held (in_ready = !out_valid | out_ready).
// Ports: clk, rst (sync, active-high); bus (slave modport): in_valid/in_ready/in1/in2,
//        out_valid/out_ready/out, overflow/underflow/invalid (zero whenever out_valid=0).
module bf16_mul_pipe #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
) (
  input  logic           clk,
  input  logic           rst,
  bf16_mul_pipe_if.slave bus
);
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int EW2        = EXP_WIDTH + 2;
  localparam int MW         = FRAC_WIDTH + 1;
  localparam int PW         = 2 * MW;
  localparam int BIAS       = (1 << (EXP_WIDTH - 1)) - 1;

  // Operand-pair class, resolved once in S1 in result priority order.
  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  localparam logic [EXP_WIDTH-1:0]  EXP_ONES   = '1;
  localparam logic [EW2-1:0]        EXP_ONES_W = {2'b00, EXP_ONES};
  localparam logic [EW2-1:0]        EXP_ZERO_W = '0;
  localparam logic [FRAC_WIDTH-1:0] FRAC_ZERO  = '0;
  localparam logic [DATA_WIDTH-1:0] QNAN       = {1'b0, EXP_ONES, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------- handshake
  logic out_valid_q, out_valid_d;
  logic advance;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // ---------------------------------------------------------------- S1: unpack/classify
  logic                  a_sign, b_sign;
  logic [EXP_WIDTH-1:0]  a_exp, b_exp;
  logic [FRAC_WIDTH-1:0] a_frac, b_frac;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [1:0]            cls;

  assign {a_sign, a_exp, a_frac} = bus.in1;
  assign {b_sign, b_exp, b_frac} = bus.in2;

  // Exponent zero means zero: subnormal fractions are ignored.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

  always_comb begin
    cls = CLS_NORM;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) cls = CLS_NAN;
    else if (a_inf || b_inf)                                       cls = CLS_INF;
    else if (a_zero || b_zero)                                     cls = CLS_ZERO;
  end

  logic           s1_vld_q, s1_vld_d;
  logic           s1_sign_q, s1_sign_d;
  logic [1:0]     s1_cls_q, s1_cls_d;
  logic [EW2-1:0] s1_exp_q, s1_exp_d;
  logic [MW-1:0]  s1_m1_q, s1_m1_d;
  logic [MW-1:0]  s1_m2_q, s1_m2_d;

  // ---------------------------------------------------------------- S2: mantissa product
  logic           s2_vld_q, s2_vld_d;
  logic           s2_sign_q, s2_sign_d;
  logic [1:0]     s2_cls_q, s2_cls_d;
  logic [EW2-1:0] s2_exp_q, s2_exp_d;
  logic [PW-1:0]  s2_prod_q, s2_prod_d;

  // ---------------------------------------------------------------- S3: normalise/round/pack
  logic [PW-1:0]         prod_n;
  logic [MW-1:0]         mant;
  logic                  guard, rnd, sticky;
  logic [MW:0]           mant_rnd;
  logic [EW2-1:0]        exp_fin;
  logic [FRAC_WIDTH-1:0] frac_fin;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_ovf, res_unf, res_inv;

  // Product of two [1,2) mantissas lies in [1,4): either the top bit or the one
  // below it is set, so a single conditional shift normalises it.
  assign prod_n   = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
  assign mant     = prod_n[PW-1 -: MW];
  assign guard    = prod_n[MW-1];
  assign rnd      = prod_n[MW-2];
  assign sticky   = |prod_n[MW-3:0];
  assign mant_rnd = {1'b0, mant} + (MW+1)'(guard & (rnd | sticky | mant[0]));
  // A carry out of rounding means the mantissa became exactly 2.0.
  assign exp_fin  = s2_exp_q + EW2'(s2_prod_q[PW-1]) + EW2'(mant_rnd[MW]);
  assign frac_fin = mant_rnd[MW] ? FRAC_ZERO : mant_rnd[FRAC_WIDTH-1:0];

  always_comb begin
    res     = {s2_sign_q, exp_fin[EXP_WIDTH-1:0], frac_fin};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_inv = 1'b0;
    case (s2_cls_q)
      CLS_NAN: begin
        res     = QNAN;
        res_inv = 1'b1;
      end
      CLS_INF:  res = {s2_sign_q, EXP_ONES, FRAC_ZERO};
      CLS_ZERO: res = {s2_sign_q, {(DATA_WIDTH-1){1'b0}}};
      default: begin
        if ($signed(exp_fin) >= $signed(EXP_ONES_W)) begin
          res     = {s2_sign_q, EXP_ONES, FRAC_ZERO};
          res_ovf = 1'b1;
        end else if ($signed(exp_fin) <= $signed(EXP_ZERO_W)) begin
          res     = {s2_sign_q, {(DATA_WIDTH-1){1'b0}}};
          res_unf = 1'b1;
        end
      end
    endcase
  end

  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  // ---------------------------------------------------------------- next state
  // Every stage moves together on advance and holds otherwise.
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_sign_d   = s1_sign_q;
    s1_cls_d    = s1_cls_q;
    s1_exp_d    = s1_exp_q;
    s1_m1_d     = s1_m1_q;
    s1_m2_d     = s1_m2_q;
    s2_vld_d    = s2_vld_q;
    s2_sign_d   = s2_sign_q;
    s2_cls_d    = s2_cls_q;
    s2_exp_d    = s2_exp_q;
    s2_prod_d   = s2_prod_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inv_d       = inv_q;
    if (advance) begin
      s1_vld_d    = bus.in_valid;
      s1_sign_d   = a_sign ^ b_sign;
      s1_cls_d    = cls;
      s1_exp_d    = EW2'(a_exp) + EW2'(b_exp) - EW2'(BIAS);
      s1_m1_d     = {1'b1, a_frac};
      s1_m2_d     = {1'b1, b_frac};
      s2_vld_d    = s1_vld_q;
      s2_sign_d   = s1_sign_q;
      s2_cls_d    = s1_cls_q;
      s2_exp_d    = s1_exp_q;
      s2_prod_d   = PW'(s1_m1_q) * PW'(s1_m2_q);
      out_valid_d = s2_vld_q;
      out_d       = res;
      // Bubbles carry no flags.
      ovf_d       = res_ovf & s2_vld_q;
      unf_d       = res_unf & s2_vld_q;
      inv_d       = res_inv & s2_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= CLS_NORM;
      s1_exp_q    <= '0;
      s1_m1_q     <= '0;
      s1_m2_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= CLS_NORM;
      s2_exp_q    <= '0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_q    <= s1_cls_d;
      s1_exp_q    <= s1_exp_d;
      s1_m1_q     <= s1_m1_d;
      s1_m2_q     <= s1_m2_d;
      s2_vld_q    <= s2_vld_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_exp_q    <= s2_exp_d;
      s2_prod_q   <= s2_prod_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inv_q       <= inv_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.invalid   = inv_q;

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Purpose: directed bench for bf16_mul_pipe with hand-computed bfloat16 products.
// Covers: reset state, 3-cycle latency, rounding, overflow/underflow, specials,
//         backpressure stall with in-order delivery, and reset with results in flight.
module tb_bf16_mul_pipe;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bf16_mul_pipe_if #(.DATA_WIDTH(16)) bus ();

  bf16_mul_pipe #(.EXP_WIDTH(8), .FRAC_WIDTH(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Flags packed as {overflow, underflow, invalid}.
  logic [2:0] flg;
  assign flg = {bus.overflow, bus.underflow, bus.invalid};

  // Directed vectors: operand A, operand B, expected product, expected flags.
  logic [15:0] va   [9] = '{16'h3FC0, 16'h3FC1, 16'h3FFF, 16'h7F00, 16'h0080,
                            16'h8000, 16'h7F80, 16'hFF80, 16'h7FC1};
  logic [15:0] vb   [9] = '{16'h4000, 16'h3FC1, 16'h3FFF, 16'h7F00, 16'h0080,
                            16'h4000, 16'h0000, 16'h4000, 16'h3F80};
  logic [15:0] vout [9] = '{16'h4040, 16'h4012, 16'h407E, 16'h7F80, 16'h0000,
                            16'h8000, 16'h7FC0, 16'hFF80, 16'h7FC0};
  logic [2:0]  vflg [9] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010,
                            3'b000, 3'b001, 3'b000, 3'b001};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One isolated operation: result must be absent two cycles after the drive
  // and present (with flags) exactly three cycles after it.
  task automatic run_vec(input int i);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in1       = va[i];
    bus.in2       = vb[i];
    @(negedge clk);
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_early", i), bus.out_valid, 0);
    @(negedge clk);
    check($sformatf("v%0d_valid", i), bus.out_valid, 1);
    check($sformatf("v%0d_out", i), bus.out, vout[i]);
    check($sformatf("v%0d_flags", i), flg, vflg[i]);
  endtask

  initial begin
    int          tx, rx;
    logic        acc_prev, was_stalled, saw_inrdy_low;
    logic [15:0] held_out;
    logic [2:0]  held_flg;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_flags", flg, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;

    // Isolated vectors.
    for (int i = 0; i < 9; i++) run_vec(i);

    // Back-to-back stream of 6 with a 4-cycle downstream stall mid-stream.
    tx            = 0;
    rx            = 0;
    acc_prev      = 1'b0;
    was_stalled   = 1'b0;
    saw_inrdy_low = 1'b0;
    held_out      = '0;
    held_flg      = '0;
    for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
      @(negedge clk);
      if (acc_prev) tx++;
      bus.out_ready = !(cyc >= 4 && cyc < 8);
      bus.in_valid  = (tx < 6);
      if (tx < 6) begin
        bus.in1 = va[tx];
        bus.in2 = vb[tx];
      end
      #1;
      if (was_stalled) begin
        check("bp_hold_out", bus.out, held_out);
        check("bp_hold_flags", flg, held_flg);
        check("bp_hold_valid", bus.out_valid, 1);
      end
      if (!bus.in_ready) saw_inrdy_low = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp%0d_out", rx), bus.out, vout[rx]);
        check($sformatf("bp%0d_flags", rx), flg, vflg[rx]);
        rx++;
      end
      was_stalled = bus.out_valid && !bus.out_ready;
      held_out    = bus.out;
      held_flg    = flg;
      acc_prev    = bus.in_valid && bus.in_ready;
    end
    check("bp_count", rx, 6);
    check("bp_inready_drop", saw_inrdy_low, 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_no_dup", bus.out_valid, 0);
    end

    // Reset with three results in flight.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in1      = va[k];
      bus.in2      = vb[k];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_inflight_valid", bus.out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_out", bus.out, 0);
    check("rst_mid_flags", flg, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_stale", bus.out_valid, 0);
    end
    run_vec(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
